// File: rtl/bam_mult_arbiter.sv
// Round-robin front end sharing one broken-array approximate 8x8
// multiplier between NREQ requesters, with a registered result port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid[NREQ]     per-requester request
//   req_a/req_b         packed operands, requester i at [8i+7:8i]
//   req_ready[NREQ]     one-hot grant (combinational on req_valid)
//   res_valid/res_ready result handshake
//   res_p, res_id       approximate product and owning requester
//   busy                operation in flight or result waiting
//   op_count            saturating count of result handshakes

module bam_mult_core #(
   parameter int HBL = 2,
   parameter int VBL = 6
) (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);

   // Rows below HBL and partial-product bits below column VBL
   // are left out of the array entirely; nothing compensates.
   always_comb begin
      p = '0;
      for (int i = HBL; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            if (i + j >= VBL) begin
               p = p + (16'(a[i] & b[j]) << (i + j));
            end
         end
      end
   end

endmodule

module bam_mult_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_a,
   input  logic [8*NREQ-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [15:0]       res_p,
   output logic [IDW-1:0]    res_id,
   output logic              busy,
   output logic [CNTW-1:0]   op_count
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      OUT
   } state_t;

   state_t         state;
   state_t         state_n;
   logic [7:0]     op_a;
   logic [7:0]     op_b;
   logic [IDW-1:0] id_reg;
   logic [IDW-1:0] last;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] idx;
   logic           found;
   logic           accept_ok;
   logic           accept;
   logic [15:0]    core_p;

   bam_mult_core u_core (
      .a (op_a),
      .b (op_b),
      .p (core_p)
   );

   // Scan starts just after the previous winner and wraps.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(last) + k) % NREQ);
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      state_n   = state;
      accept_ok = 1'b0;
      unique case (state)
         IDLE: begin
            accept_ok = 1'b1;
            if (found) state_n = CALC;
         end
         CALC: state_n = OUT;
         OUT: begin
            if (res_ready) begin
               accept_ok = 1'b1;
               state_n   = found ? CALC : IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign accept    = accept_ok & found;
   assign req_ready = accept ? (NREQ'(1) << winner) : '0;
   assign res_valid = (state == OUT);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         op_a     <= '0;
         op_b     <= '0;
         id_reg   <= '0;
         last     <= IDW'(NREQ - 1);
         res_p    <= '0;
         res_id   <= '0;
         op_count <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            op_a   <= req_a[int'(winner) * 8 +: 8];
            op_b   <= req_b[int'(winner) * 8 +: 8];
            id_reg <= winner;
            last   <= winner;
         end
         if (state == CALC) begin
            res_p  <= core_p;
            res_id <= id_reg;
         end
         if (res_valid && res_ready && (op_count != '1)) begin
            op_count <= op_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bam_mult_arbiter.sv
// Directed bench for bam_mult_arbiter: per-cycle model compare plus
// hand-computed literal expectations.

module tb_bam_mult_arbiter;

   localparam int NREQ = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        res_ready;
   logic [3:0]  req_ready;
   logic        res_valid;
   logic [15:0] res_p;
   logic [1:0]  res_id;
   logic        busy;
   logic [15:0] op_count;

   logic [3:0]  req_ready2;
   logic        res_valid2;
   logic [15:0] res_p2;
   logic [1:0]  res_id2;
   logic        busy2;
   logic [2:0]  op_count2;

   always #5 clk = ~clk;

   bam_mult_arbiter #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_p     (res_p),
      .res_id    (res_id),
      .busy      (busy),
      .op_count  (op_count)
   );

   // Narrow counter copy so saturation is reachable quickly.
   bam_mult_arbiter #(.NREQ(4), .IDW(2), .CNTW(3)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready2),
      .res_valid (res_valid2),
      .res_ready (res_ready),
      .res_p     (res_p2),
      .res_id    (res_id2),
      .busy      (busy2),
      .op_count  (op_count2)
   );

   int passes = 0;
   int total  = 0;

   bit          m_calc;
   bit          m_rv;
   logic [15:0] m_p;
   int          m_id;
   int          m_last;
   int          m_cnt;
   int          m_cnt2;
   logic [7:0]  m_oa;
   logic [7:0]  m_ob;
   int          m_oid;
   int          grant_log[$];

   function automatic logic [15:0] approx(input logic [7:0] a,
                                          input logic [7:0] b);
      int p = 0;
      for (int i = 2; i < 8; i++) begin
         int lo = (6 - i > 0) ? 6 - i : 0;
         int mask = (255 >> lo) << lo;
         if (a[i]) p += (int'(b) & mask) << i;
      end
      return p[15:0];
   endfunction

   function automatic int exp_winner();
      for (int k = 1; k <= NREQ; k++) begin
         int w = (m_last + k) % NREQ;
         if (req_valid[w]) return w;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic model_reset();
      m_calc = 0;
      m_rv   = 0;
      m_p    = '0;
      m_id   = 0;
      m_last = NREQ - 1;
      m_cnt  = 0;
      m_cnt2 = 0;
      m_oa   = '0;
      m_ob   = '0;
      m_oid  = 0;
   endtask

   task automatic model_update();
      bit acc_ok;
      int w;
      if (rst) begin
         model_reset();
         return;
      end
      acc_ok = (!m_calc && !m_rv) || (m_rv && res_ready);
      w = exp_winner();
      if (m_rv && res_ready) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt2 < 7) m_cnt2++;
         m_rv = 0;
      end
      if (m_calc) begin
         m_rv   = 1;
         m_p    = approx(m_oa, m_ob);
         m_id   = m_oid;
         m_calc = 0;
      end
      if (acc_ok && w >= 0) begin
         m_oa   = req_a[w*8 +: 8];
         m_ob   = req_b[w*8 +: 8];
         m_oid  = w;
         m_last = w;
         m_calc = 1;
      end
   endtask

   task automatic compare_all();
      bit acc_ok;
      int w;
      int exp_rr;
      acc_ok = (!m_calc && !m_rv) || (m_rv && res_ready);
      w = exp_winner();
      exp_rr = (acc_ok && w >= 0) ? (1 << w) : 0;
      chk("req_ready", req_ready, exp_rr);
      chk("res_valid", res_valid, m_rv);
      chk("res_p", res_p, m_p);
      chk("res_id", res_id, m_id);
      chk("busy", busy, m_calc | m_rv);
      chk("op_count", op_count, m_cnt);
      chk("op_count_sat3", op_count2, m_cnt2);
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i] && req_valid[i]) grant_log.push_back(i);
      end
   endtask

   task automatic neg_check();
      @(negedge clk);
      compare_all();
   endtask

   task automatic edge_step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic cyc();
      neg_check();
      edge_step();
   endtask

   task automatic run_one(input int id, input logic [7:0] a,
                          input logic [7:0] b, input int exp_p);
      req_valid = 4'(1 << id);
      req_a[id*8 +: 8] = a;
      req_b[id*8 +: 8] = b;
      neg_check();
      chk("grant_single", req_ready, 1 << id);
      edge_step();
      req_valid = '0;
      cyc();
      neg_check();
      chk("lit_res_valid", res_valid, 1);
      chk("lit_res_p", res_p, exp_p);
      chk("lit_res_id", res_id, id);
      edge_step();
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int exp_order[6];
      logic [15:0] hold_p;
      logic [1:0]  hold_id;
      exp_order = '{0, 1, 2, 3, 0, 1};

      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b0;
      model_reset();
      #1;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_p", res_p, 0);
      chk("rst_busy", busy, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_req_ready", req_ready, 0);
      edge_step();
      edge_step();
      rst = 1'b0;
      res_ready = 1'b1;
      cyc();

      run_one(0, 8'h40, 8'h05, 16'h0140);
      chk("lit_op_count_1", op_count, 1);
      run_one(1, 8'hFF, 8'hFF, 16'hFA40);
      run_one(2, 8'h01, 8'hFF, 16'h0000);
      run_one(3, 8'h80, 8'h03, 16'h0180);

      req_a = 32'h9C_37_A5_11;
      req_b = 32'h0F_E2_66_C3;
      req_valid = 4'hF;
      grant_log.delete();
      repeat (12) cyc();
      chk("grant_count", grant_log.size(), 6);
      for (int i = 0; i < 6; i++) begin
         chk("grant_order", (i < grant_log.size()) ? grant_log[i] : -1,
             exp_order[i]);
      end

      res_ready = 1'b0;
      neg_check();
      chk("lit_op_count_9", op_count, 9);
      chk("stall_res_id", res_id, 1);
      hold_p  = res_p;
      hold_id = res_id;
      edge_step();
      repeat (4) begin
         neg_check();
         chk("stall_p", res_p, hold_p);
         chk("stall_id", res_id, hold_id);
         chk("stall_ready", req_ready, 0);
         edge_step();
      end
      res_ready = 1'b1;
      neg_check();
      chk("release_grant", req_ready, 4'b0100);
      edge_step();
      req_valid = '0;
      repeat (4) cyc();

      req_valid = 4'b0010;
      neg_check();
      chk("lit_op_count_11", op_count, 11);
      chk("lit_op_count_sat", op_count2, 7);
      edge_step();
      req_valid = '0;
      rst = 1'b1;
      model_reset();
      #1;
      chk("mid_rst_res_valid", res_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_res_p", res_p, 0);
      chk("mid_rst_res_id", res_id, 0);
      chk("mid_rst_op_count", op_count, 0);
      edge_step();
      rst = 1'b0;
      cyc();
      chk("no_ghost_result", res_valid, 0);
      req_valid = 4'b0011;
      req_a[7:0] = 8'h40;
      req_b[7:0] = 8'h05;
      neg_check();
      chk("post_rst_grant", req_ready, 1);
      edge_step();
      req_valid = '0;
      cyc();
      neg_check();
      chk("post_rst_id", res_id, 0);
      chk("post_rst_p", res_p, 16'h0140);
      edge_step();
      repeat (3) cyc();

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
